// File: rtl/riscv_alu_share_arbiter.sv
// Shares one basic ALU between NUM_REQ requesters: arbitrate, issue, return the response.
// Build option ALU_ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins) instead of round-robin.
module riscv_alu_share_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ALU_OP_WIDTH = 7,
  parameter int ID_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid_i,
  output logic [NUM_REQ-1:0]               req_ready_o,
  input  logic [NUM_REQ*ALU_OP_WIDTH-1:0]  req_operator_i,
  input  logic [NUM_REQ*32-1:0]            req_operand_a_i,
  input  logic [NUM_REQ*32-1:0]            req_operand_b_i,
  input  logic [NUM_REQ*2-1:0]             req_vector_mode_i,
  output logic [NUM_REQ-1:0]               resp_valid_o,
  input  logic [NUM_REQ-1:0]               resp_ready_i,
  output logic [31:0]                      resp_result_o,
  output logic                             resp_cmp_o,
  output logic [ALU_OP_WIDTH-1:0]          alu_operator_o,
  output logic [31:0]                      alu_operand_a_o,
  output logic [31:0]                      alu_operand_b_o,
  output logic [1:0]                       alu_vector_mode_o,
  output logic                             alu_en_o,
  input  logic [31:0]                      alu_result_i,
  input  logic                             alu_cmp_i,
  input  logic                             alu_ready_i,
  output logic                             busy_o,
  output logic [ID_W-1:0]                  grant_id_o,
  output logic [31:0]                      op_count_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ID_W-1:0]         r_owner;
  logic [ALU_OP_WIDTH-1:0] r_op;
  logic [31:0]             r_opa;
  logic [31:0]             r_opb;
  logic [1:0]              r_vm;
  logic [31:0]             r_result;
  logic                    r_cmp;
  logic [NUM_REQ-1:0]      r_resp_valid;
  logic [31:0]             r_op_count;

  logic                    w_hs;
  logic                    w_arb_en;
  logic                    w_grant;
  logic                    w_issue_done;
  logic                    w_win_found;
  int                      w_win_idx;
  int                      w_scan;
  logic [NUM_REQ-1:0]      w_ready;
  logic [NUM_REQ-1:0]      w_owner_oh;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]         r_rr_ptr;
  logic [ID_W-1:0]         w_rr_nxt;
`endif

  // Only the owner can have resp_valid set, so masking ignores non-owner resp_ready.
  assign w_hs         = |(r_resp_valid & resp_ready_i);
  assign w_arb_en     = ~rst & ((r_state == S_IDLE) | ((r_state == S_RESP) & w_hs));
  assign w_grant      = w_arb_en & w_win_found;
  assign w_issue_done = (r_state == S_ISSUE) & alu_ready_i;

  // Winner search: first valid requester at or after the scan start, wrapping upward.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = 0;
    w_scan      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w_scan = i;
`else
      w_scan = int'(r_rr_ptr) + i;
      if (w_scan >= NUM_REQ) begin
        w_scan = w_scan - NUM_REQ;
      end else begin
        w_scan = w_scan;
      end
`endif
      if (!w_win_found && req_valid_i[w_scan]) begin
        w_win_found = 1'b1;
        w_win_idx   = w_scan;
      end else begin
        w_win_found = w_win_found;
      end
    end
  end

  // One-hot decodes for the grant strobe and the response owner.
  always_comb begin
    w_ready    = '0;
    w_owner_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_ready[i]    = w_grant & (w_win_idx == i);
      w_owner_oh[i] = (int'(r_owner) == i);
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  assign w_rr_nxt = ((w_win_idx + 1) >= NUM_REQ) ? '0 : ID_W'(w_win_idx + 1);
`endif

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_state_nxt = S_ISSUE;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (alu_ready_i) begin
          w_state_nxt = S_RESP;
        end else begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_RESP: begin
        if (w_hs) begin
          w_state_nxt = w_grant ? S_ISSUE : S_IDLE;
        end else begin
          w_state_nxt = S_RESP;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture the winning operation; ALU inputs stay stable until the next grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner <= '0;
      r_op    <= '0;
      r_opa   <= 32'd0;
      r_opb   <= 32'd0;
      r_vm    <= 2'd0;
    end else if (w_grant) begin
      r_owner <= ID_W'(w_win_idx);
      r_op    <= req_operator_i[w_win_idx*ALU_OP_WIDTH +: ALU_OP_WIDTH];
      r_opa   <= req_operand_a_i[w_win_idx*32 +: 32];
      r_opb   <= req_operand_b_i[w_win_idx*32 +: 32];
      r_vm    <= req_vector_mode_i[w_win_idx*2 +: 2];
    end
  end

`ifndef ALU_ARB_FIXED_PRIO_EN
  // Round-robin pointer moves just past the latest winner.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_grant) begin
      r_rr_ptr <= w_rr_nxt;
    end
  end
`endif

  // Result capture, response valid and completed-operation counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_result     <= 32'd0;
      r_cmp        <= 1'b0;
      r_resp_valid <= '0;
      r_op_count   <= 32'd0;
    end else begin
      if (w_issue_done) begin
        r_result     <= alu_result_i;
        r_cmp        <= alu_cmp_i;
        r_resp_valid <= w_owner_oh;
      end else if (w_hs) begin
        r_resp_valid <= '0;
      end
      if (w_hs) begin
        r_op_count <= r_op_count + 32'd1;
      end
    end
  end

  assign req_ready_o       = w_ready;
  assign resp_valid_o      = r_resp_valid;
  assign resp_result_o     = r_result;
  assign resp_cmp_o        = r_cmp;
  assign alu_operator_o    = r_op;
  assign alu_operand_a_o   = r_opa;
  assign alu_operand_b_o   = r_opb;
  assign alu_vector_mode_o = r_vm;
  assign alu_en_o          = (r_state == S_ISSUE);
  assign busy_o            = (r_state != S_IDLE);
  assign grant_id_o        = r_owner;
  assign op_count_o        = r_op_count;

endmodule

// File: tb/tb_riscv_alu_share_arbiter.sv
// Directed self-checking bench for riscv_alu_share_arbiter with a small behavioural ALU stub.
module tb_riscv_alu_share_arbiter;

  localparam logic [6:0] ALU_ADD  = 7'b0011000;
  localparam logic [6:0] ALU_SUB  = 7'b0011001;
  localparam logic [6:0] ALU_SLTS = 7'b0000010;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [27:0]  req_op;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [7:0]   req_vm;
  logic [3:0]   resp_valid;
  logic [3:0]   resp_ready;
  logic [31:0]  resp_result;
  logic         resp_cmp;
  logic [6:0]   alu_op;
  logic [31:0]  alu_a;
  logic [31:0]  alu_b;
  logic [1:0]   alu_vm;
  logic         alu_en;
  logic [31:0]  alu_res;
  logic         alu_cmp;
  logic         alu_ready;
  logic         busy;
  logic [1:0]   grant_id;
  logic [31:0]  op_count;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  riscv_alu_share_arbiter #(.NUM_REQ(4), .ALU_OP_WIDTH(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_operator_i(req_op), .req_operand_a_i(req_a), .req_operand_b_i(req_b),
    .req_vector_mode_i(req_vm),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_result_o(resp_result), .resp_cmp_o(resp_cmp),
    .alu_operator_o(alu_op), .alu_operand_a_o(alu_a), .alu_operand_b_o(alu_b),
    .alu_vector_mode_o(alu_vm), .alu_en_o(alu_en),
    .alu_result_i(alu_res), .alu_cmp_i(alu_cmp), .alu_ready_i(alu_ready),
    .busy_o(busy), .grant_id_o(grant_id), .op_count_o(op_count)
  );

  // ALU stub: only the operators the bench uses.
  always_comb begin
    alu_res = 32'd0;
    alu_cmp = 1'b0;
    case (alu_op)
      ALU_ADD:  alu_res = alu_a + alu_b;
      ALU_SUB:  alu_res = alu_a - alu_b;
      ALU_SLTS: begin
        alu_cmp = ($signed(alu_a) < $signed(alu_b));
        alu_res = {31'd0, alu_cmp};
      end
      default:  alu_res = 32'd0;
    endcase
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic set_req(input int r, input logic [6:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[r*7 +: 7]  = op;
    req_a[r*32 +: 32] = a;
    req_b[r*32 +: 32] = b;
    req_vm[r*2 +: 2]  = 2'd0;
  endtask

  task automatic do_reset;
    rst        = 1'b1;
    req_valid  = 4'd0;
    req_op     = '0;
    req_a      = '0;
    req_b      = '0;
    req_vm     = '0;
    resp_ready = 4'hF;
    alu_ready  = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    rst       = 1'b1;
    req_valid = 4'hF;
    #1;
    tests_run++;
    if (req_ready !== 4'd0) begin tests_failed++; $display("FAIL reset_ready: got %b exp 0000", req_ready); end
    tests_run++;
    if ({resp_valid, resp_result, resp_cmp, alu_op, alu_a, alu_b, alu_vm, alu_en, busy, grant_id, op_count} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: valid=%b res=%h op=%h a=%h busy=%b cnt=%0d exp all zero",
               resp_valid, resp_result, alu_op, alu_a, busy, op_count);
    end
    req_valid = 4'd0;
    rst       = 1'b0;
  endtask

  task automatic test_single_op;
    do_reset;
    set_req(2, ALU_ADD, 32'h0000_0005, 32'h0000_0003);
    req_valid = 4'b0100;
    #1;
    tests_run++;
    if (req_ready !== 4'b0100) begin tests_failed++; $display("FAIL single_ready: got %b exp 0100", req_ready); end
    tick;
    req_valid = 4'd0;
    #1;
    tests_run++;
    if (alu_en !== 1'b1 || alu_op !== ALU_ADD || alu_a !== 32'd5 || alu_b !== 32'd3 || grant_id !== 2'd2) begin
      tests_failed++;
      $display("FAIL single_issue: en=%b op=%h a=%h b=%h id=%0d exp 1/%h/5/3/2", alu_en, alu_op, alu_a, alu_b, grant_id, ALU_ADD);
    end
    tests_run++;
    if (resp_valid !== 4'd0) begin tests_failed++; $display("FAIL single_early_resp: got %b exp 0000", resp_valid); end
    tick;
    #1;
    tests_run++;
    if (resp_valid !== 4'b0100 || resp_result !== 32'h8) begin
      tests_failed++;
      $display("FAIL single_resp: valid=%b res=%h exp 0100/8", resp_valid, resp_result);
    end
    tick;
    #1;
    tests_run++;
    if (op_count !== 32'd1 || busy !== 1'b0 || resp_valid !== 4'd0) begin
      tests_failed++;
      $display("FAIL single_done: cnt=%0d busy=%b valid=%b exp 1/0/0000", op_count, busy, resp_valid);
    end
  endtask

  task automatic test_contention;
    logic [3:0]  exp_rdy;
    logic [3:0]  exp_vld;
    logic [31:0] exp_res;
    do_reset;
    for (int r = 0; r < 4; r++) set_req(r, ALU_SUB, 32'd10, 32'(r));
    req_valid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      #1;
      exp_rdy = 4'b0001 << k;
      tests_run++;
      if (req_ready !== exp_rdy) begin tests_failed++; $display("FAIL contention_grant%0d: got %b exp %b", k, req_ready, exp_rdy); end
      if (k > 0) begin
        exp_vld = 4'b0001 << (k - 1);
        exp_res = 32'(11 - k);
        tests_run++;
        if (resp_valid !== exp_vld || resp_result !== exp_res) begin
          tests_failed++;
          $display("FAIL contention_resp%0d: valid=%b res=%0d exp %b/%0d", k, resp_valid, resp_result, exp_vld, exp_res);
        end
      end
      tick;
      req_valid[k] = 1'b0;
      #1;
      tests_run++;
      if (grant_id !== 2'(k) || alu_b !== 32'(k) || req_ready !== 4'd0) begin
        tests_failed++;
        $display("FAIL contention_issue%0d: id=%0d b=%0d rdy=%b exp %0d/%0d/0000", k, grant_id, alu_b, req_ready, k, k);
      end
      tick;
    end
    #1;
    tests_run++;
    if (resp_valid !== 4'b1000 || resp_result !== 32'd7 || req_ready !== 4'd0) begin
      tests_failed++;
      $display("FAIL contention_last: valid=%b res=%0d rdy=%b exp 1000/7/0000", resp_valid, resp_result, req_ready);
    end
    tick;
    req_valid = 4'b0011;
    #1;
    tests_run++;
    if (op_count !== 32'd4 || busy !== 1'b0 || req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL contention_wrap: cnt=%0d busy=%b rdy=%b exp 4/0/0001", op_count, busy, req_ready);
    end
    req_valid = 4'd0;
  endtask

  task automatic test_resp_stall;
    do_reset;
    resp_ready = 4'b0010;
    set_req(0, ALU_ADD, 32'd1, 32'd2);
    req_valid = 4'b0001;
    tick;
    req_valid = 4'b0010;
    set_req(1, ALU_ADD, 32'd4, 32'd4);
    tick;
    for (int i = 0; i < 5; i++) begin
      #1;
      tests_run++;
      if (resp_valid !== 4'b0001 || resp_result !== 32'd3 || req_ready !== 4'd0) begin
        tests_failed++;
        $display("FAIL stall_hold%0d: valid=%b res=%0d rdy=%b exp 0001/3/0000", i, resp_valid, resp_result, req_ready);
      end
      tick;
    end
    resp_ready = 4'b0011;
    #1;
    tests_run++;
    if (req_ready !== 4'b0010) begin tests_failed++; $display("FAIL stall_release_grant: got %b exp 0010", req_ready); end
    tick;
    req_valid = 4'd0;
    #1;
    tests_run++;
    if (op_count !== 32'd1 || grant_id !== 2'd1 || resp_valid !== 4'd0 || alu_en !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_next_issue: cnt=%0d id=%0d valid=%b en=%b exp 1/1/0000/1", op_count, grant_id, resp_valid, alu_en);
    end
    tick;
    #1;
    tests_run++;
    if (resp_valid !== 4'b0010 || resp_result !== 32'd8) begin
      tests_failed++;
      $display("FAIL stall_second_resp: valid=%b res=%0d exp 0010/8", resp_valid, resp_result);
    end
    tick;
    #1;
    tests_run++;
    if (op_count !== 32'd2) begin tests_failed++; $display("FAIL stall_count: got %0d exp 2", op_count); end
  endtask

  task automatic test_alu_not_ready;
    do_reset;
    alu_ready = 1'b0;
    set_req(3, ALU_SLTS, 32'hFFFF_FFFF, 32'h0000_0001);
    req_valid = 4'b1000;
    #1;
    tests_run++;
    if (req_ready !== 4'b1000) begin tests_failed++; $display("FAIL aluwait_grant: got %b exp 1000", req_ready); end
    tick;
    req_valid = 4'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if (alu_en !== 1'b1 || alu_op !== ALU_SLTS || alu_a !== 32'hFFFF_FFFF || alu_b !== 32'd1 || resp_valid !== 4'd0) begin
        tests_failed++;
        $display("FAIL aluwait_hold%0d: en=%b op=%h a=%h b=%h valid=%b", i, alu_en, alu_op, alu_a, alu_b, resp_valid);
      end
      tick;
    end
    alu_ready = 1'b1;
    tick;
    #1;
    tests_run++;
    if (resp_valid !== 4'b1000 || resp_result !== 32'h1 || resp_cmp !== 1'b1) begin
      tests_failed++;
      $display("FAIL aluwait_resp: valid=%b res=%h cmp=%b exp 1000/1/1", resp_valid, resp_result, resp_cmp);
    end
    tick;
  endtask

  task automatic test_reset_mid_op;
    do_reset;
    set_req(1, ALU_ADD, 32'd9, 32'd9);
    req_valid = 4'b0010;
    tick;
    req_valid = 4'd0;
    alu_ready = 1'b0;
    rst       = 1'b1;
    #1;
    tests_run++;
    if (busy !== 1'b0 || alu_en !== 1'b0 || alu_a !== 32'd0 || alu_op !== 7'd0 || grant_id !== 2'd0 ||
        resp_valid !== 4'd0 || op_count !== 32'd0) begin
      tests_failed++;
      $display("FAIL midreset_clear: busy=%b en=%b a=%h op=%h id=%0d valid=%b cnt=%0d exp all zero",
               busy, alu_en, alu_a, alu_op, grant_id, resp_valid, op_count);
    end
    tick;
    alu_ready = 1'b1;
    #1;
    tests_run++;
    if (resp_valid !== 4'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_hold: valid=%b busy=%b exp 0000/0", resp_valid, busy);
    end
    tick;
    rst = 1'b0;
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    set_req(2, ALU_ADD, 32'd2, 32'd2);
    req_valid = 4'b0101;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin tests_failed++; $display("FAIL midreset_first_grant: got %b exp 0001", req_ready); end
    req_valid = 4'd0;
  endtask

  task automatic test_priority_mode;
    logic [3:0] exp_rdy;
    do_reset;
    set_req(0, ALU_ADD, 32'd1, 32'd1);
    set_req(3, ALU_ADD, 32'd2, 32'd2);
    req_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      #1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_rdy = 4'b0001;
`else
      exp_rdy = (k % 2 == 0) ? 4'b0001 : 4'b1000;
`endif
      tests_run++;
      if (req_ready !== exp_rdy) begin tests_failed++; $display("FAIL prio_grant%0d: got %b exp %b", k, req_ready, exp_rdy); end
      tick;
      tick;
    end
    req_valid = 4'd0;
    tick;
    tick;
  endtask

  initial begin
    rst = 1'b1;
    test_reset;
    test_single_op;
    test_contention;
    test_resp_stall;
    test_alu_not_ready;
    test_reset_mid_op;
    test_priority_mode;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
